// File: rtl/plcounter_bounded_if.sv
// Control/data bundle for plcounter_bounded: the counter consumes the i_* signals (slave)
// and returns the o_* signals; the master side drives it.
interface plcounter_bounded_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);
  logic              i_en;
  logic              i_load;
  logic              i_updown;
  logic              i_sat;
  logic [STEP_W-1:0] i_step;
  logic [WIDTH-1:0]  i_lo;
  logic [WIDTH-1:0]  i_hi;
  logic [WIDTH-1:0]  i_in;
  logic [WIDTH-1:0]  o_out;
  logic              o_tc;
  logic              o_ovf;
  logic              o_cfg_err;

  modport master (
    output i_en, i_load, i_updown, i_sat, i_step, i_lo, i_hi, i_in,
    input  o_out, o_tc, o_ovf, o_cfg_err
  );

  modport slave (
    input  i_en, i_load, i_updown, i_sat, i_step, i_lo, i_hi, i_in,
    output o_out, o_tc, o_ovf, o_cfg_err
  );
endinterface

// File: rtl/plcounter_bounded.sv
// Bounded up/down counter with programmable step, wrap/saturate, terminal-count pulse and
// sticky overflow. Optional enable prescaler is compiled in with PLCOUNTER_PRESCALE_EN.
module plcounter_bounded #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned RST_VAL  = 0,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  plcounter_bounded_if.slave   bus
);

  // One extra bit so the carry/borrow of out +/- step is never aliased.
  localparam int unsigned CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  if (PRESCALE == 0) begin : g_bad_prescale
    $error("plcounter_bounded: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             r_tc_q, r_tc_d;
  logic             r_ovf_q, r_ovf_d;

  logic             w_cfg_err;
  logic             w_fire;
  logic [CW-1:0]    w_out_ext, w_step_ext, w_lo_ext, w_hi_ext;
  logic [CW-1:0]    w_up_sum, w_dn_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_clamped;

`ifdef PLCOUNTER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] r_pre_q, r_pre_d;
`endif

  always_comb begin
    w_cfg_err  = bus.i_lo > bus.i_hi;
    w_out_ext  = CW'(r_out_q);
    w_step_ext = CW'(bus.i_step);
    w_lo_ext   = CW'(bus.i_lo);
    w_hi_ext   = CW'(bus.i_hi);
    w_up_sum   = w_out_ext + w_step_ext;
    w_dn_diff  = w_out_ext - w_step_ext;
    w_borrow   = w_out_ext < w_step_ext;
    if (bus.i_in < bus.i_lo) begin
      w_clamped = bus.i_lo;
    end else if (bus.i_in > bus.i_hi) begin
      w_clamped = bus.i_hi;
    end else begin
      w_clamped = bus.i_in;
    end
  end

  always_comb begin
    r_out_d = r_out_q;
    r_tc_d  = 1'b0;
    r_ovf_d = r_ovf_q;
    w_fire  = 1'b0;
`ifdef PLCOUNTER_PRESCALE_EN
    r_pre_d = r_pre_q;
`endif
    if (bus.i_load) begin
      // With inverted bounds there is no valid range to clamp into.
      r_out_d = w_cfg_err ? bus.i_in : w_clamped;
      r_ovf_d = 1'b0;
`ifdef PLCOUNTER_PRESCALE_EN
      r_pre_d = '0;
`endif
    end else if (bus.i_en) begin
`ifdef PLCOUNTER_PRESCALE_EN
      if (r_pre_q == PW'(PRESCALE - 1)) begin
        r_pre_d = '0;
        w_fire  = 1'b1;
      end else begin
        r_pre_d = r_pre_q + PW'(1);
      end
`else
      w_fire = 1'b1;
`endif
      if (w_fire && !w_cfg_err && (bus.i_step != '0)) begin
        if (bus.i_updown) begin
          if (w_up_sum > w_hi_ext) begin
            r_out_d = bus.i_sat ? bus.i_hi : bus.i_lo;
            r_tc_d  = 1'b1;
            r_ovf_d = 1'b1;
          end else begin
            r_out_d = w_up_sum[WIDTH-1:0];
          end
        end else begin
          if (w_borrow || (w_dn_diff < w_lo_ext)) begin
            r_out_d = bus.i_sat ? bus.i_lo : bus.i_hi;
            r_tc_d  = 1'b1;
            r_ovf_d = 1'b1;
          end else begin
            r_out_d = w_dn_diff[WIDTH-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_q <= WIDTH'(RST_VAL);
      r_tc_q  <= 1'b0;
      r_ovf_q <= 1'b0;
    end else begin
      r_out_q <= r_out_d;
      r_tc_q  <= r_tc_d;
      r_ovf_q <= r_ovf_d;
    end
  end

`ifdef PLCOUNTER_PRESCALE_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre_q <= '0;
    end else begin
      r_pre_q <= r_pre_d;
    end
  end
`endif

  assign bus.o_out     = r_out_q;
  assign bus.o_tc      = r_tc_q;
  assign bus.o_ovf     = r_ovf_q;
  assign bus.o_cfg_err = w_cfg_err;

endmodule

// File: tb/tb_plcounter_bounded.sv
// Self-checking bench for plcounter_bounded: integer reference model compared every cycle,
// plus directed sequences with literal expectations.
module tb_plcounter_bounded;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned STEP_W   = 4;
  localparam int unsigned RST_VAL  = 0;
  localparam int unsigned PRESCALE = 4;

  logic clk;
  logic rst;

  plcounter_bounded_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  plcounter_bounded #(
    .WIDTH(WIDTH), .STEP_W(STEP_W), .RST_VAL(RST_VAL), .PRESCALE(PRESCALE)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Reference model state, in plain integers.
  int m_out = 0;
  int m_tc  = 0;
  int m_ovf = 0;
  int m_pre = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int lo, hi, st, nxt;
    bit fire;
    lo = int'(bus.i_lo);
    hi = int'(bus.i_hi);
    st = int'(bus.i_step);
    if (rst) begin
      m_out = RST_VAL; m_tc = 0; m_ovf = 0; m_pre = 0;
    end else if (bus.i_load) begin
      m_tc = 0; m_ovf = 0; m_pre = 0;
      if (lo > hi)                    m_out = int'(bus.i_in);
      else if (int'(bus.i_in) < lo)   m_out = lo;
      else if (int'(bus.i_in) > hi)   m_out = hi;
      else                            m_out = int'(bus.i_in);
    end else begin
      m_tc = 0;
      if (bus.i_en) begin
        fire = 1'b1;
`ifdef PLCOUNTER_PRESCALE_EN
        fire  = (m_pre == PRESCALE - 1);
        m_pre = fire ? 0 : m_pre + 1;
`endif
        if (fire && lo <= hi && st != 0) begin
          if (bus.i_updown) begin
            nxt = m_out + st;
            if (nxt > hi) begin
              m_tc = 1; m_ovf = 1; m_out = bus.i_sat ? hi : lo;
            end else m_out = nxt;
          end else begin
            nxt = m_out - st;
            if (nxt < lo) begin
              m_tc = 1; m_ovf = 1; m_out = bus.i_sat ? lo : hi;
            end else m_out = nxt;
          end
        end
      end
    end
    if (rst) chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_out", int'(bus.o_out), m_out);
      chk("model_tc", int'(bus.o_tc), m_tc);
      chk("model_ovf", int'(bus.o_ovf), m_ovf);
      chk("model_cfg_err", int'(bus.o_cfg_err), int'(bus.i_lo > bus.i_hi));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string name, input int o, input int t, input int v);
    chk({name, "_out"}, int'(bus.o_out), o);
    chk({name, "_tc"}, int'(bus.o_tc), t);
    chk({name, "_ovf"}, int'(bus.o_ovf), v);
  endtask

  initial begin
    int lo_r;
    rst = 1'b1;
    bus.i_en = 1'b0; bus.i_load = 1'b0; bus.i_updown = 1'b1; bus.i_sat = 1'b0;
    bus.i_step = '0; bus.i_lo = '0; bus.i_hi = 8'd255; bus.i_in = '0;
    tick();
    expect3("reset", 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect3("hold", 0, 0, 0);
    end

`ifndef PLCOUNTER_PRESCALE_EN
    // Up wrap
    bus.i_lo = 8'd2; bus.i_hi = 8'd10; bus.i_in = 8'd8; bus.i_load = 1'b1;
    tick();
    expect3("upw_load", 8, 0, 0);
    bus.i_load = 1'b0; bus.i_updown = 1'b1; bus.i_step = 4'd3; bus.i_sat = 1'b0;
    bus.i_en = 1'b1;
    tick(); expect3("upw_1", 2, 1, 1);
    tick(); expect3("upw_2", 5, 0, 1);
    tick(); expect3("upw_3", 8, 0, 1);
    tick(); expect3("upw_4", 2, 1, 1);
    // Down saturate
    bus.i_in = 8'd4; bus.i_load = 1'b1;
    tick(); expect3("dns_load", 4, 0, 0);
    bus.i_load = 1'b0; bus.i_updown = 1'b0; bus.i_sat = 1'b1;
    tick(); expect3("dns_1", 2, 1, 1);
    tick(); expect3("dns_2", 2, 1, 1);
    tick(); expect3("dns_3", 2, 1, 1);
    bus.i_in = 8'd0; bus.i_load = 1'b1;
    tick(); expect3("dns_clamp", 2, 0, 0);
    // Priority
    rst = 1'b1; bus.i_in = 8'd7;
    tick(); expect3("prio_rst", RST_VAL, 0, 0);
    rst = 1'b0; bus.i_in = 8'd20; bus.i_updown = 1'b1;
    tick(); expect3("prio_load", 10, 0, 0);
    // Config error
    bus.i_load = 1'b0; bus.i_lo = 8'd9; bus.i_hi = 8'd3;
    #1 chk("cfg_err_hi", int'(bus.o_cfg_err), 1);
    tick(); expect3("cfg_frozen", 10, 0, 0);
    bus.i_in = 8'd200; bus.i_load = 1'b1;
    tick(); expect3("cfg_load_raw", 200, 0, 0);
    // Full range carry
    bus.i_lo = 8'd0; bus.i_hi = 8'd255; bus.i_in = 8'd254; bus.i_sat = 1'b0;
    #1 chk("cfg_err_lo", int'(bus.o_cfg_err), 0);
    tick(); expect3("full_load", 254, 0, 0);
    bus.i_load = 1'b0; bus.i_step = 4'd5;
    tick(); expect3("full_wrap", 0, 1, 1);
    // Exactly at hi, and step = 0
    bus.i_lo = 8'd2; bus.i_hi = 8'd10; bus.i_in = 8'd10; bus.i_load = 1'b1;
    tick();
    bus.i_load = 1'b0; bus.i_step = 4'd0;
    tick(); expect3("step0", 10, 0, 0);
    bus.i_step = 4'd1; bus.i_sat = 1'b1;
    tick(); expect3("at_hi", 10, 1, 1);
    bus.i_en = 1'b0;
    tick(); expect3("en_off", 10, 0, 1);
`else
    // Prescale: increment every PRESCALE enabled cycles, en low freezes the prescaler.
    bus.i_lo = 8'd0; bus.i_hi = 8'd255; bus.i_step = 4'd1; bus.i_updown = 1'b1;
    bus.i_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("pre_run", int'(bus.o_out), (i >= PRESCALE) ? 1 : 0);
    end
    bus.i_en = 1'b0;
    tick(); chk("pre_gap1", int'(bus.o_out), 1);
    tick(); chk("pre_gap2", int'(bus.o_out), 1);
    bus.i_en = 1'b1;
    tick(); chk("pre_resume1", int'(bus.o_out), (PRESCALE == 4) ? 1 : m_out);
    tick(); chk("pre_resume2", int'(bus.o_out), (PRESCALE == 4) ? 2 : m_out);
`endif

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      bus.i_load = ($urandom_range(0, 7) == 0);
      bus.i_en   = ($urandom_range(0, 3) != 0);
      bus.i_updown = 1'($urandom);
      bus.i_sat  = 1'($urandom);
      bus.i_step = STEP_W'($urandom);
      bus.i_in   = WIDTH'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        bus.i_lo = WIDTH'($urandom); bus.i_hi = WIDTH'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        lo_r = $urandom_range(0, 255);
        bus.i_lo = WIDTH'(lo_r);
        bus.i_hi = WIDTH'($urandom_range(lo_r, 255));
      end
      tick();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
